// File: rtl/atm_pin_entry_if.sv
// Keypad/card inputs and verdict outputs between the PIN entry unit and the ATM controller.
// The controller side drives the keypad and card signals; the PIN unit drives the verdict and status.
interface atm_pin_entry_if #(
  parameter int PIN_DIGITS = 4
);
  logic                    card_inserted;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [4*PIN_DIGITS-1:0] stored_pin;
  logic                    pin_entered;
  logic                    pin_correct;
  logic [3:0]              digit_count;
  logic [1:0]              tries_left;
  logic                    card_retain;
  logic [2:0]              state;

  modport master (
    output card_inserted, key_valid, key_code, stored_pin,
    input  pin_entered, pin_correct, digit_count, tries_left, card_retain, state
  );

  modport slave (
    input  card_inserted, key_valid, key_code, stored_pin,
    output pin_entered, pin_correct, digit_count, tries_left, card_retain, state
  );
endinterface

// File: rtl/atm_pin_entry.sv
// PIN entry and verification: buffers keypad digits, compares them with the card PIN on Enter,
// and counts failed attempts, locking out and retaining the card after the last one.
module atm_pin_entry #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           reset,
  atm_pin_entry_if.slave bus
);
  localparam int         W            = 4 * PIN_DIGITS;
  localparam logic [3:0] DIGITS       = 4'(PIN_DIGITS);
  localparam logic [1:0] TRIES_INIT   = 2'(MAX_TRIES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COLLECT  = 3'd1;
  localparam logic [2:0] VERIFIED = 3'd2;
  localparam logic [2:0] LOCKED   = 3'd3;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  logic [2:0]   state_reg,   state_next;
  logic [W-1:0] buffer_reg,  buffer_next;
  logic [3:0]   count_reg,   count_next;
  logic [1:0]   tries_reg,   tries_next;
  logic [15:0]  timer_reg,   timer_next;
  logic         entered_reg, entered_next;
  logic         correct_reg, correct_next;
  logic         retain_reg,  retain_next;

  logic [PIN_DIGITS-1:0] nibble_eq;
  logic                  pin_match;

  genvar gi;
  generate
    for (gi = 0; gi < PIN_DIGITS; gi++) begin : g_cmp
      assign nibble_eq[gi] = (buffer_reg[4*gi +: 4] == bus.stored_pin[4*gi +: 4]);
    end
  endgenerate
  assign pin_match = &nibble_eq;

  always_comb begin
    state_next   = state_reg;
    buffer_next  = buffer_reg;
    count_next   = count_reg;
    tries_next   = tries_reg;
    timer_next   = timer_reg;
    entered_next = 1'b0;
    correct_next = correct_reg;
    retain_next  = retain_reg;

    if (state_reg == IDLE) begin
      if (bus.card_inserted) begin
        state_next  = COLLECT;
        tries_next  = TRIES_INIT;
        buffer_next = '0;
        count_next  = '0;
        timer_next  = '0;
      end
    end else if (!bus.card_inserted) begin
      // Card removal wins over any key, Enter included, and is the only way out of LOCKED.
      state_next   = IDLE;
      buffer_next  = '0;
      count_next   = '0;
      tries_next   = '0;
      timer_next   = '0;
      correct_next = 1'b0;
      retain_next  = 1'b0;
    end else if (state_reg == COLLECT) begin
      if (bus.key_valid) begin
        timer_next = '0;
        if (bus.key_code <= 4'd9) begin
          if (count_reg < DIGITS) begin
            buffer_next = (buffer_reg << 4) | W'(bus.key_code);
            count_next  = count_reg + 4'd1;
          end
        end else if (bus.key_code == KEY_CLEAR) begin
          buffer_next = '0;
          count_next  = '0;
        end else if (bus.key_code == KEY_ENTER && count_reg == DIGITS) begin
          entered_next = 1'b1;
          correct_next = pin_match;
          buffer_next  = '0;
          count_next   = '0;
          if (pin_match) begin
            state_next = VERIFIED;
          end else if (tries_reg > 2'd1) begin
            tries_next = tries_reg - 2'd1;
          end else begin
            tries_next  = '0;
            retain_next = 1'b1;
            state_next  = LOCKED;
          end
        end
      end else if (timer_reg == TIMEOUT_LAST) begin
        // Idle too long: drop the partial entry without spending an attempt.
        timer_next  = '0;
        buffer_next = '0;
        count_next  = '0;
      end else begin
        timer_next = timer_reg + 16'd1;
      end
    end else if (state_reg != VERIFIED && state_reg != LOCKED) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      buffer_reg  <= '0;
      count_reg   <= '0;
      tries_reg   <= '0;
      timer_reg   <= '0;
      entered_reg <= 1'b0;
      correct_reg <= 1'b0;
      retain_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      buffer_reg  <= buffer_next;
      count_reg   <= count_next;
      tries_reg   <= tries_next;
      timer_reg   <= timer_next;
      entered_reg <= entered_next;
      correct_reg <= correct_next;
      retain_reg  <= retain_next;
    end
  end

  assign bus.pin_entered = entered_reg;
  assign bus.pin_correct = correct_reg;
  assign bus.digit_count = count_reg;
  assign bus.tries_left  = tries_reg;
  assign bus.card_retain = retain_reg;
  assign bus.state       = state_reg;
endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed and randomized checks of atm_pin_entry against a digit-queue reference model.
module tb_atm_pin_entry;
  localparam int PD = 4;
  localparam int MT = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_pin_entry_if #(.PIN_DIGITS(PD)) bus ();

  atm_pin_entry #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: card PIN as a digit array, entry as a queue of digits.
  int pin_d [PD];
  int m_digits [$];
  int m_state, m_tries, m_idle;
  bit m_entered, m_correct, m_retain;
  bit card_now;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_state = 0; m_tries = 0; m_idle = 0;
    m_entered = 0; m_correct = 0; m_retain = 0;
  endtask

  task automatic model_update(input bit card, input bit kv, input logic [3:0] code);
    bit ok;
    m_entered = 0;
    if (m_state == 0) begin
      if (card) begin
        m_state = 1; m_tries = MT; m_idle = 0; m_digits.delete();
      end
    end else if (!card) begin
      model_reset();
    end else if (m_state == 1) begin
      if (kv) begin
        m_idle = 0;
        if (code < 10) begin
          if (m_digits.size() < PD) m_digits.push_back(int'(code));
        end else if (code == 4'hA) begin
          m_digits.delete();
        end else if (code == 4'hB && m_digits.size() == PD) begin
          ok = 1;
          for (int i = 0; i < PD; i++) if (m_digits[i] != pin_d[i]) ok = 0;
          m_entered = 1;
          m_correct = ok;
          m_digits.delete();
          if (ok) m_state = 2;
          else begin
            m_tries--;
            if (m_tries == 0) begin
              m_retain = 1;
              m_state = 3;
            end
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_idle = 0;
          m_digits.delete();
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pin_entered"}, 32'(bus.pin_entered), 32'(m_entered));
    chk({tag, " pin_correct"}, 32'(bus.pin_correct), 32'(m_correct));
    chk({tag, " digit_count"}, 32'(bus.digit_count), 32'(m_digits.size()));
    chk({tag, " tries_left"},  32'(bus.tries_left),  32'(m_tries));
    chk({tag, " card_retain"}, 32'(bus.card_retain), 32'(m_retain));
    chk({tag, " state"},       32'(bus.state),       32'(m_state));
  endtask

  task automatic set_pin(input logic [4*PD-1:0] p);
    bus.stored_pin = p;
    for (int i = 0; i < PD; i++) pin_d[i] = int'(p[4*(PD-1-i) +: 4]);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic step(input bit card, input bit kv, input logic [3:0] code, input string tag);
    bus.card_inserted = card;
    bus.key_valid     = kv;
    bus.key_code      = code;
    @(posedge clk);
    model_update(card, kv, code);
    #1;
    check_model(tag);
    $display("step %-10s card=%0b kv=%0b key=%h -> state=%0d cnt=%0d tries=%0d ent=%0b ok=%0b ret=%0b",
             tag, card, kv, code, bus.state, bus.digit_count, bus.tries_left,
             bus.pin_entered, bus.pin_correct, bus.card_retain);
  endtask

  task automatic press(input logic [3:0] code, input string tag);
    step(1'b1, 1'b1, code, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, tag);
  endtask

  task automatic enter_pin(input logic [4*PD-1:0] p, input string tag);
    logic [4*PD-1:0] v;
    v = p;
    for (int i = PD - 1; i >= 0; i--) press(v[4*i +: 4], tag);
    press(4'hB, tag);
  endtask

  initial begin
    int r, guess;
    logic [4*PD-1:0] np;

    reset = 1'b0;
    bus.card_inserted = 1'b0;
    bus.key_valid     = 1'b0;
    bus.key_code      = 4'h0;
    set_pin(16'h1234);
    model_reset();
    #12;
    check_model("reset");
    reset = 1'b1;

    // 1: correct PIN first time
    step(1'b1, 1'b0, 4'h0, "t1_insert");
    chk("t1 tries_init", 32'(bus.tries_left), 32'd3);
    enter_pin(16'h1234, "t1_enter");
    chk("t1 pulse", 32'(bus.pin_entered), 32'd1);
    chk("t1 correct", 32'(bus.pin_correct), 32'd1);
    chk("t1 state", 32'(bus.state), 32'd2);
    idle(1, "t1_after");
    chk("t1 pulse_drop", 32'(bus.pin_entered), 32'd0);
    enter_pin(16'h1234, "t1_ignored");
    chk("t1 no_pulse", 32'(bus.pin_entered), 32'd0);
    step(1'b0, 1'b0, 4'h0, "t1_remove");

    // 2: one wrong, then right
    step(1'b1, 1'b0, 4'h0, "t2_insert");
    enter_pin(16'h1235, "t2_wrong");
    chk("t2 wrong_correct", 32'(bus.pin_correct), 32'd0);
    chk("t2 tries", 32'(bus.tries_left), 32'd2);
    chk("t2 state", 32'(bus.state), 32'd1);
    enter_pin(16'h1234, "t2_right");
    chk("t2 verified", 32'(bus.state), 32'd2);
    step(1'b0, 1'b0, 4'h0, "t2_remove");

    // 3: lockout
    step(1'b1, 1'b0, 4'h0, "t3_insert");
    for (int k = 0; k < MT; k++) enter_pin(16'h9999, "t3_wrong");
    chk("t3 retain", 32'(bus.card_retain), 32'd1);
    chk("t3 locked", 32'(bus.state), 32'd3);
    chk("t3 tries", 32'(bus.tries_left), 32'd0);
    enter_pin(16'h1234, "t3_locked");
    chk("t3 no_pulse", 32'(bus.pin_entered), 32'd0);
    step(1'b0, 1'b0, 4'h0, "t3_remove");
    chk("t3 released", 32'(bus.card_retain), 32'd0);

    // 4: editing
    step(1'b1, 1'b0, 4'h0, "t4_insert");
    press(4'h1, "t4"); press(4'h2, "t4"); press(4'hB, "t4_short");
    chk("t4 short_enter", 32'(bus.pin_entered), 32'd0);
    press(4'hA, "t4_clear");
    chk("t4 cleared", 32'(bus.digit_count), 32'd0);
    press(4'h1, "t4"); press(4'h2, "t4"); press(4'h3, "t4"); press(4'h4, "t4"); press(4'h9, "t4_extra");
    chk("t4 full", 32'(bus.digit_count), 32'd4);
    press(4'hB, "t4_enter");
    chk("t4 correct", 32'(bus.pin_correct), 32'd1);
    step(1'b0, 1'b0, 4'h0, "t4_remove");

    // 5: timeout, and Enter coinciding with card removal
    step(1'b1, 1'b0, 4'h0, "t5_insert");
    press(4'h1, "t5"); press(4'h2, "t5");
    idle(TO - 1, "t5_idle");
    chk("t5 not_yet", 32'(bus.digit_count), 32'd2);
    idle(1, "t5_timeout");
    chk("t5 timeout", 32'(bus.digit_count), 32'd0);
    chk("t5 tries", 32'(bus.tries_left), 32'd3);
    press(4'h1, "t5"); press(4'h2, "t5"); press(4'h3, "t5"); press(4'h4, "t5");
    step(1'b0, 1'b1, 4'hB, "t5_rm_enter");
    chk("t5 no_pulse", 32'(bus.pin_entered), 32'd0);
    chk("t5 idle", 32'(bus.state), 32'd0);

    // 6: asynchronous reset mid-entry
    step(1'b1, 1'b0, 4'h0, "t6_insert");
    enter_pin(16'h9999, "t6_wrong");
    press(4'h1, "t6"); press(4'h2, "t6"); press(4'h3, "t6");
    chk("t6 count", 32'(bus.digit_count), 32'd3);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_model("t6_async");
    chk("t6 state", 32'(bus.state), 32'd0);
    #2 reset = 1'b1;
    step(1'b1, 1'b0, 4'h0, "t6_resume");
    chk("t6 tries", 32'(bus.tries_left), 32'd3);
    step(1'b0, 1'b0, 4'h0, "t6_remove");

    // Randomized traffic
    card_now = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (!card_now) begin
        if (r < 30) begin
          for (int i = 0; i < PD; i++)
            np[4*(PD-1-i) +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                                : 4'($urandom_range(0, 9));
          set_pin(np);
          step(1'b1, 1'b0, 4'h0, "rnd_insert");
          card_now = 1;
        end else begin
          step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rnd_nocard");
        end
      end else if (r < 55) begin
        if (m_digits.size() < PD && $urandom_range(0, 3) != 0 && pin_d[m_digits.size()] < 10)
          guess = pin_d[m_digits.size()];
        else
          guess = $urandom_range(0, 9);
        press(4'(guess), "rnd_digit");
      end else if (r < 70) begin
        press(4'hB, "rnd_enter");
      end else if (r < 74) begin
        press(4'hA, "rnd_clear");
      end else if (r < 78) begin
        press(4'($urandom_range(12, 15)), "rnd_junk");
      end else if (r < 92) begin
        idle(1, "rnd_idle");
      end else if (r < 94) begin
        idle(TO, "rnd_long");
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rnd_remove");
        card_now = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
